// File: rtl/expr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : expr_line_buffer
// Purpose  : Collects calculator keystrokes into a line and, on newline, packs
//            it into a 256-bit expression, pulses calc_start and waits for the
//            calculator. Optional feature macro: BACKSPACE_EN (0x08 deletes).
// Revision : 1.0 - initial release
// ============================================================================
module expr_line_buffer #(
  parameter int MAX_LEN = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic         char_ready,
  output logic [255:0] line_out,
  output logic         calc_start,
  input  logic         calc_done,
  output logic [4:0]   len_out,
  output logic         overflow,
  output logic         busy
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_PACK    = 2'd1;
  localparam logic [1:0] S_START   = 2'd2;
  localparam logic [1:0] S_BUSY    = 2'd3;

  localparam logic [7:0] c_NEWLINE = 8'h0A;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic [7:0]   r_buf [0:MAX_LEN-1];
  logic [4:0]   r_len;
  logic         r_overflow;
  logic         r_armed;
  logic [255:0] r_line;
  logic [255:0] w_line;
  logic         w_fire;
  logic         w_is_nl;
  logic         w_is_bs;
  logic         w_storable;
  logic         w_full;
  logic         w_done;

  assign w_fire  = char_valid && char_ready;
  assign w_is_nl = (char_in == c_NEWLINE);
  assign w_full  = (r_len == 5'(MAX_LEN));
  // The calculator still shows the previous result's finished flag right after
  // start, so completion only counts once calc_done has been seen low.
  assign w_done  = r_armed && calc_done;

  assign w_storable = ((char_in >= 8'h30) && (char_in <= 8'h39)) ||
                      (char_in == 8'h2B) || (char_in == 8'h2D) ||
                      (char_in == 8'h2A) || (char_in == 8'h2F) ||
                      (char_in == 8'h28) || (char_in == 8'h29) ||
                      (char_in == 8'h20);

`ifdef BACKSPACE_EN
  localparam logic [7:0] c_BACKSPACE = 8'h08;
  assign w_is_bs = (char_in == c_BACKSPACE);
`else
  assign w_is_bs = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: if (w_fire && w_is_nl && (r_len != 5'd0)) w_next = S_PACK;
      S_PACK:    w_next = S_START;
      S_START:   w_next = S_BUSY;
      S_BUSY:    if (w_done) w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  always_comb begin
    char_ready = (r_state == S_COLLECT);
    calc_start = (r_state == S_START);
    busy       = (r_state != S_COLLECT);
  end

  // Packed image: stored chars, then newline terminator, then zero fill.
  for (genvar j = 0; j < 32; j++) begin : g_pack
    if (j < MAX_LEN) begin : g_data
      assign w_line[255-8*j -: 8] = (5'(j) < r_len)  ? r_buf[j]  :
                                    (5'(j) == r_len) ? c_NEWLINE : 8'h00;
    end else begin : g_tail
      assign w_line[255-8*j -: 8] = (5'(j) == r_len) ? c_NEWLINE : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_COLLECT && w_fire && w_storable && !w_full) begin
      r_buf[r_len] <= char_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= 5'd0;
      r_overflow <= 1'b0;
      r_armed    <= 1'b0;
      r_line     <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_fire) begin
            if (w_storable) begin
              if (w_full) r_overflow <= 1'b1;
              else        r_len      <= r_len + 5'd1;
            end else if (w_is_bs && (r_len != 5'd0)) begin
              r_len <= r_len - 5'd1;
            end
          end
        end
        S_PACK:  r_line  <= w_line;
        S_START: r_armed <= 1'b0;
        S_BUSY: begin
          if (w_done) begin
            r_len      <= 5'd0;
            r_overflow <= 1'b0;
          end else if (!calc_done) begin
            r_armed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign line_out = r_line;
  assign len_out  = r_len;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_expr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_line_buffer
// Purpose  : Self-checking bench: queue-based line model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_line_buffer;

  localparam int MAX = 30;
`ifdef BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   char_in = 8'h00;
  logic         char_valid = 1'b0;
  logic         char_ready;
  logic [255:0] line_out;
  logic         calc_start;
  logic         calc_done = 1'b1;
  logic [4:0]   len_out;
  logic         overflow;
  logic         busy;

  expr_line_buffer #(.MAX_LEN(MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .line_out   (line_out),
    .calc_start (calc_start),
    .calc_done  (calc_done),
    .len_out    (len_out),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_starts = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned m_q[$];
  bit           m_ovf = 1'b0;
  logic [255:0] m_line = '0;
  int           m_phase = 0;   // 0 collecting, 1 pack, 2 start, 3 waiting
  bit           m_armed = 1'b0;
  bit           m_valid = 1'b0;

  function automatic bit storable(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || c == 8'h2B || c == 8'h2D ||
           c == 8'h2A || c == 8'h2F || c == 8'h28 || c == 8'h29 || c == 8'h20;
  endfunction

  always @(posedge clk) begin
    logic [7:0] b;
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_line  = '0;
      m_phase = 0;
      m_armed = 1'b0;
      m_valid = 1'b1;
    end else begin
      case (m_phase)
        0: if (char_valid) begin
          if (char_in == 8'h0A) begin
            if (m_q.size() > 0) m_phase = 1;
          end else if (storable(char_in)) begin
            if (m_q.size() < MAX) m_q.push_back(char_in);
            else m_ovf = 1'b1;
          end else if (BS_EN && char_in == 8'h08 && m_q.size() > 0) begin
            void'(m_q.pop_back());
          end
        end
        1: begin
          for (int j = 0; j < 32; j++) begin
            if (j < m_q.size())       b = m_q[j];
            else if (j == m_q.size()) b = 8'h0A;
            else                      b = 8'h00;
            m_line[255-8*j -: 8] = b;
          end
          m_phase = 2;
        end
        2: begin
          m_phase = 3;
          m_armed = 1'b0;
        end
        default: begin
          if (m_armed && calc_done) begin
            m_phase = 0;
            m_q.delete();
            m_ovf = 1'b0;
          end else if (!calc_done) begin
            m_armed = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("char_ready", char_ready, m_phase == 0);
      check("busy",       busy,       m_phase != 0);
      check("calc_start", calc_start, m_phase == 2);
      check("len_out",    len_out,    m_q.size());
      check("overflow",   overflow,   m_ovf);
      check("line_out",   line_out,   m_line);
    end
    if (calc_start === 1'b1) n_starts++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    char_in = c;
    char_valid = 1'b1;
    while (!char_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) timeout("send_wait");
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!calc_start && n < 10);
    if (!calc_start) timeout("wait_start");
  endtask

  // Stub: keep done high one extra cycle, drop it two cycles, then raise it.
  task automatic finish_calc();
    int n = 0;
    @(negedge clk);
    @(negedge clk);
    check("busy_ignores_stale_done", busy, 1'b1);
    calc_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("still_busy_before_rise", char_ready, 1'b0);
    calc_done = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!char_ready && n < 20);
    if (!char_ready) timeout("finish_calc");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s0;
    repeat (2) @(negedge clk);
    check("rst_line_out", line_out, '0);
    check("rst_len_out",  len_out, 5'd0);
    check("rst_ready",    char_ready, 1'b1);
    check("rst_busy",     busy, 1'b0);
    rst = 1'b0;

    // "1+2\n", latency, packed image, held char during BUSY
    send(8'h31); send(8'h2B); send(8'h32);
    send(8'h0A);
    wait_start(lat);
    check("start_latency", lat, 2);
    check("pack_1p2", line_out[255:216], 40'h312B320A00);
    check("len_at_start", len_out, 5'd3);
    check("busy_at_start", busy, 1'b1);
    char_in = 8'h35;
    char_valid = 1'b1;
    finish_calc();
    check("len_cleared", len_out, 5'd0);
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(negedge clk);
    check("held_char_taken", len_out, 5'd1);

    // overflow: 31 sevens
    pulse_reset();
    for (int i = 0; i < 31; i++) send(8'h37);
    send(8'h0A);
    wait_start(lat);
    check("ovf_len", len_out, 5'd30);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_byte0", line_out[255:248], 8'h37);
    check("ovf_byte30", line_out[15:8], 8'h0A);
    check("ovf_byte31", line_out[7:0], 8'h00);
    finish_calc();
    check("ovf_cleared", overflow, 1'b0);

    // lone newline and an unsupported char
    s0 = n_starts;
    send(8'h0A);
    send(8'h78);
    repeat (3) @(negedge clk);
    check("empty_nl_len", len_out, 5'd0);
    check("empty_nl_no_start", n_starts, s0);
    check("empty_nl_ready", char_ready, 1'b1);

    // backspace handling
    send(8'h39); send(8'h08); send(8'h08); send(8'h34);
    send(8'h0A);
    wait_start(lat);
`ifdef BACKSPACE_EN
    check("bs_line", line_out[255:232], 24'h340A00);
`else
    check("bs_line", line_out[255:232], 24'h39340A);
`endif
    finish_calc();

    // reset in the middle of BUSY
    send(8'h38);
    send(8'h0A);
    wait_start(lat);
    @(negedge clk);
    @(negedge clk);
    s0 = n_starts;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy_busy", busy, 1'b0);
    check("rst_busy_line", line_out, '0);
    check("rst_busy_ready", char_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("rst_busy_no_start", n_starts, s0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/expr_line_buffer.md
EXPR_LINE_BUFFER -- requirements
Module: expr_line_buffer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 30, the maximum number of visible characters per line (excluding terminator).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port char_in  input  8  ASCII character from keyboard/UART front end.
REQ-005 SHALL have port char_valid  input  1  char_in valid this cycle.
REQ-006 SHALL have port char_ready  output  1  buffer accepts a character this cycle.
REQ-007 SHALL have port line_out  output  256  packed expression for the calculator; char j at bits [255-8j : 248-8j].
REQ-008 SHALL have port calc_start  output  1  one-cycle pulse, wired to the calculator's rst.
REQ-009 SHALL have port calc_done  input  1  calculator finished flag.
REQ-010 SHALL have port len_out  output  5  count of characters currently buffered.
REQ-011 SHALL have port overflow  output  1  sticky; a character was dropped because the line was full.
REQ-012 SHALL have port busy  output  1  high while a committed line is being evaluated.

Function
REQ-013 SHALL implement FSM states COLLECT, PACK, START, BUSY; char_ready = (state == COLLECT), combinational.
REQ-014 A character SHALL transfer only on a cycle with char_valid && char_ready.
REQ-015 In COLLECT, accepted chars "0"-"9", "+", "-", "*", "/", "(", ")", " " SHALL be stored at index len_out, then len_out increments.
REQ-016 In COLLECT, any other accepted char (except "\n" and handled 0x08) SHALL be consumed and discarded, with no state change.
REQ-017 In COLLECT, a storable char arriving when len_out == MAX_LEN SHALL be discarded and SHALL set overflow to 1.
REQ-018 "\n" (0x0A) with len_out == 0 SHALL be discarded.
REQ-019 "\n" with len_out > 0 SHALL move COLLECT -> PACK on the next edge.
REQ-020 In PACK (1 cycle), line_out SHALL be loaded as follows: chars 0..len-1 in order, then 0x0A at index len, then 0x00 in all higher indices; then go to START.
REQ-021 In START, calc_start SHALL be 1 for exactly that one cycle, with line_out already stable; then go to BUSY.
REQ-022 line_out SHALL remain unchanged from PACK until the next PACK.
REQ-023 In BUSY, calc_done SHALL be ignored until it has been sampled 0 at least once after START, since the calculator clears finished only after its Init state.
REQ-024 In BUSY, once that arming condition is met, calc_done == 1 SHALL cause return to COLLECT, with len_out and overflow cleared on the same edge.
REQ-025 busy SHALL equal 1 in PACK, START and BUSY, and 0 in COLLECT.
REQ-026 Total latency from the "\n" handshake edge to calc_start high SHALL be 2 cycles.
REQ-027 Characters presented while char_ready == 0 SHALL NOT be consumed; the upstream source holds them.

Reset
REQ-028 rst SHALL force COLLECT from any state, including mid-BUSY, on the next edge.
REQ-029 Reset values SHALL be: line_out = 0, len_out = 0, overflow = 0, calc_start = 0, busy = 0, char_ready = 1 after the reset edge.
REQ-030 The buffer contents SHALL be treated as empty after reset, and no calc_start pulse SHALL be emitted because of reset.

Configuration
REQ-031 Macro BACKSPACE_EN SHALL control backspace handling.
REQ-032 With BACKSPACE_EN defined, in COLLECT an accepted 0x08 SHALL decrement len_out if len_out > 0, and SHALL do nothing otherwise; overflow is unaffected.
REQ-033 Without BACKSPACE_EN, 0x08 SHALL be handled as an unsupported char per REQ-016.

Verification
REQ-034 Send "1","+","2","\n": len_out 3 -> PACK; line_out[255:216] = 31 2B 32 0A 00 (hex); calc_start high 2 cycles after the "\n" handshake; busy = 1.
REQ-035 Calculator stub holds calc_done = 1 through START, drops it for 2 cycles, then raises it: buffer stays BUSY until the rise, then char_ready = 1 and len_out = 0.
REQ-036 Send 31 digits "7" then "\n": len_out = 30, overflow = 1, line_out byte 30 = 0x0A and byte 31 = 0x00.
REQ-037 Send "\n" alone, then "x": len_out stays 0, no calc_start, char_ready stays 1.
REQ-038 With BACKSPACE_EN: "9", 0x08, 0x08, "4", "\n" -> line_out bytes 0..1 = 34 0A. Without BACKSPACE_EN: same stimulus -> 39 34 0A.
REQ-039 Assert rst during BUSY: next cycle state = COLLECT, line_out = 0, busy = 0, and no calc_start is ever pulsed.
